// File: rtl/pc_unit.sv
// Registered MIPS program counter: sequential/branch/jump/jr flow, stall-deferred redirects,
// exception entry with EPC and eret. Optional misaligned-target check under PC_ALIGN_CHECK_EN.
module pc_unit #(
    parameter int          ADDR_BITS    = 32,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 stall,
    input  logic                 pcsel,
    input  logic                 jmp,
    input  logic                 jr,
    input  logic [15:0]          imm_16,
    input  logic [25:0]          imm_26,
    input  logic [31:0]          regfile_out1,
    input  logic                 exc_req,
    input  logic [ADDR_BITS-1:0] exc_pc,
    input  logic                 eret,
    output logic [ADDR_BITS-1:0] pc,
    output logic [ADDR_BITS-1:0] pc_plus4,
    output logic [ADDR_BITS-1:0] epc,
    output logic                 redirect_pending,
    output logic                 addr_err
);
    localparam logic [ADDR_BITS-1:0] RST_PC = RESET_VECTOR[ADDR_BITS-1:0];
    localparam logic [ADDR_BITS-1:0] EXC_PC = EXC_VECTOR[ADDR_BITS-1:0];

    logic [ADDR_BITS-1:0] r_pc;
    logic [ADDR_BITS-1:0] r_epc;
    logic [ADDR_BITS-1:0] r_ptgt;
    logic                 r_pend;

    logic [ADDR_BITS-1:0] w_pc_plus4;
    logic [31:0]          w_br_off;
    logic [ADDR_BITS-1:0] w_br_tgt;
    logic [ADDR_BITS-1:0] w_j_tgt;
    logic [ADDR_BITS-1:0] w_jr_tgt;
    logic [ADDR_BITS-1:0] w_tgt;
    logic                 w_req;
    logic                 w_fault;

    assign w_pc_plus4 = r_pc + ADDR_BITS'(4);
    assign w_br_off   = {{14{imm_16[15]}}, imm_16, 2'b00};
    assign w_br_tgt   = w_pc_plus4 + w_br_off[ADDR_BITS-1:0];
    assign w_j_tgt    = {w_pc_plus4[ADDR_BITS-1:28], imm_26, 2'b00};
    assign w_jr_tgt   = regfile_out1[ADDR_BITS-1:0];
    assign w_req      = jmp | pcsel;

    // jmp outranks pcsel; jr only qualifies a jmp
    always_comb begin
        w_tgt = w_br_tgt;
        if (jmp && jr)
            w_tgt = w_jr_tgt;
        else if (jmp)
            w_tgt = w_j_tgt;
    end

`ifdef PC_ALIGN_CHECK_EN
    logic [ADDR_BITS-1:0] w_fault_addr;
    logic                 r_addr_err;
    // Only jr/eret targets can be misaligned; branch and jump targets are word-built
    assign w_fault_addr = eret ? r_epc : w_jr_tgt;
    assign w_fault      = ~exc_req & (eret ? (|r_epc[1:0]) : (jmp & jr & (|w_jr_tgt[1:0])));
    assign addr_err     = r_addr_err;
`else
    assign w_fault      = 1'b0;
    assign addr_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc   <= RST_PC;
            r_epc  <= '0;
            r_ptgt <= '0;
            r_pend <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            r_addr_err <= 1'b0;
`endif
        end else begin
`ifdef PC_ALIGN_CHECK_EN
            r_addr_err <= w_fault;
`endif
            if (exc_req) begin
                r_pc   <= EXC_PC;
                r_epc  <= exc_pc;
                r_pend <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            end else if (w_fault) begin
                r_pc   <= EXC_PC;
                r_epc  <= w_fault_addr;
                r_pend <= 1'b0;
`endif
            end else if (eret) begin
                r_pc   <= r_epc;
                r_pend <= 1'b0;
            end else if (w_req) begin
                if (stall) begin
                    // latest request within a stall overwrites the held target
                    r_ptgt <= w_tgt;
                    r_pend <= 1'b1;
                end else begin
                    r_pc   <= w_tgt;
                    r_pend <= 1'b0;
                end
            end else if (!stall) begin
                r_pc   <= r_pend ? r_ptgt : w_pc_plus4;
                r_pend <= 1'b0;
            end
        end
    end

    assign pc               = r_pc;
    assign pc_plus4         = w_pc_plus4;
    assign epc              = r_epc;
    assign redirect_pending = r_pend;
endmodule

// File: tb/tb_pc_unit.sv
// Directed test-plan steps followed by random flow requests, checked against a behavioural PC model.
module tb_pc_unit;
    localparam logic [31:0] RV = 32'hBFC0_0000;
    localparam logic [31:0] EV = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0, pcsel = 1'b0, jmp = 1'b0, jr = 1'b0;
    logic [15:0] imm_16 = '0;
    logic [25:0] imm_26 = '0;
    logic [31:0] regfile_out1 = '0;
    logic        exc_req = 1'b0, eret = 1'b0;
    logic [31:0] exc_pc = '0;
    logic [31:0] pc, pc_plus4, epc;
    logic        redirect_pending, addr_err;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [31:0] m_pc, m_epc, m_ptgt;
    logic        m_pend, m_aerr;

    pc_unit #(.ADDR_BITS(32), .RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
        .clk(clk), .resetn(resetn), .stall(stall), .pcsel(pcsel), .jmp(jmp), .jr(jr),
        .imm_16(imm_16), .imm_26(imm_26), .regfile_out1(regfile_out1),
        .exc_req(exc_req), .exc_pc(exc_pc), .eret(eret),
        .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
        .redirect_pending(redirect_pending), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        chk({tag, ".epc"}, epc, m_epc);
        chk({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, m_pend});
        chk({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, m_aerr});
    endtask

    function automatic logic misaligned(input logic [31:0] a);
        return (a % 4) != 0;
    endfunction

    // Next-state rules of the PC unit, evaluated on the inputs sampled at the edge.
    task automatic model_edge();
        logic [31:0] seq, tgt;
        seq    = m_pc + 32'd4;
        m_aerr = 1'b0;
        if (jmp && jr)  tgt = regfile_out1;
        else if (jmp)   tgt = (seq & 32'hF000_0000) | ({6'd0, imm_26} * 4);
        else            tgt = seq + 32'($signed(imm_16)) * 4;
        if (exc_req) begin
            m_pc = EV; m_epc = exc_pc; m_pend = 1'b0;
        end else if (eret) begin
`ifdef PC_ALIGN_CHECK_EN
            if (misaligned(m_epc)) begin m_pc = EV; m_aerr = 1'b1; end
            else m_pc = m_epc;
`else
            m_pc = m_epc;
`endif
            m_pend = 1'b0;
        end else if (jmp || pcsel) begin
`ifdef PC_ALIGN_CHECK_EN
            if (jmp && jr && misaligned(tgt)) begin
                m_pc = EV; m_epc = tgt; m_aerr = 1'b1; m_pend = 1'b0;
            end else
`endif
            if (stall) begin m_ptgt = tgt; m_pend = 1'b1; end
            else       begin m_pc = tgt;   m_pend = 1'b0; end
        end else if (!stall) begin
            m_pc   = m_pend ? m_ptgt : seq;
            m_pend = 1'b0;
        end
    endtask

    task automatic step(input string tag, input logic st, input logic ps, input logic jm,
                        input logic j_r, input logic [15:0] i16, input logic [25:0] i26,
                        input logic [31:0] rf, input logic ex, input logic [31:0] ep,
                        input logic er);
        stall = st; pcsel = ps; jmp = jm; jr = j_r; imm_16 = i16; imm_26 = i26;
        regfile_out1 = rf; exc_req = ex; exc_pc = ep; eret = er;
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic idle(input string tag, input logic st);
        step(tag, st, 0, 0, 0, '0, '0, '0, 0, '0, 0);
    endtask

    initial begin
        m_pc = RV; m_epc = '0; m_ptgt = '0; m_pend = 1'b0; m_aerr = 1'b0;
        #12;
        chk_all("reset");
        @(posedge clk); #1 resetn = 1'b1;

        idle("seq1", 0); chk("seq1.lit", pc, 32'hBFC0_0004);
        idle("seq2", 0); chk("seq2.lit", pc, 32'hBFC0_0008);
        idle("seq3", 0); chk("seq3.lit", pc, 32'hBFC0_000C);

        step("jr_setup", 0, 0, 1, 1, '0, '0, 32'h0040_0010, 0, '0, 0);
        step("branch_back", 0, 1, 0, 0, 16'hFFFE, '0, '0, 0, '0, 0);
        chk("branch.lit", pc, 32'h0040_000C);
        step("jump", 0, 1, 1, 0, 16'h0004, 26'h0000100, '0, 0, '0, 0);
        chk("jump.lit", pc, 32'h0000_0400);

        step("stall_jr", 1, 0, 1, 1, '0, '0, 32'h0040_1000, 0, '0, 0);
        chk("stall_jr.hold", pc, 32'h0000_0400);
        for (int i = 0; i < 3; i++) idle("stall_hold", 1);
        chk("stall_hold.pend", {31'd0, redirect_pending}, 32'd1);
        idle("release", 0);
        chk("release.lit", pc, 32'h0040_1000);

        step("stall_br", 1, 1, 0, 0, 16'h0010, '0, '0, 0, '0, 0);
        step("exc_stall", 1, 0, 0, 0, '0, '0, '0, 1, 32'h0040_0020, 0);
        chk("exc.lit", pc, EV);
        chk("exc.epc", epc, 32'h0040_0020);
        step("eret", 0, 0, 0, 0, '0, '0, '0, 0, '0, 1);
        chk("eret.lit", pc, 32'h0040_0020);

        step("jr_top", 0, 0, 1, 1, '0, '0, 32'hFFFF_FFFC, 0, '0, 0);
        idle("wrap", 0);
        chk("wrap.lit", pc, 32'h0000_0000);

        step("jr_mis", 0, 0, 1, 1, '0, '0, 32'h0040_1002, 0, '0, 0);
`ifdef PC_ALIGN_CHECK_EN
        chk("jr_mis.lit", pc, EV);
        chk("jr_mis.epc", epc, 32'h0040_1002);
        chk("jr_mis.err", {31'd0, addr_err}, 32'd1);
`else
        chk("jr_mis.lit", pc, 32'h0040_1002);
        chk("jr_mis.err", {31'd0, addr_err}, 32'd0);
`endif
        idle("after_mis", 0);

        for (int n = 0; n < 400; n++) begin
            int r;
            logic [31:0] rf, ep;
            r  = int'($urandom_range(0, 99));
            rf = $urandom; ep = $urandom;
            if ($urandom_range(0, 3) != 0) rf[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) ep[1:0] = 2'b00;
            step("rand", $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 2, 1'($urandom_range(0, 1)),
                 16'($urandom), 26'($urandom), rf, r < 4, ep, r >= 4 && r < 8);
        end

        // async reset while a deferred redirect is held
        step("pre_rst", 1, 0, 1, 0, '0, 26'h123, '0, 0, '0, 0);
        chk("pre_rst.pend", {31'd0, redirect_pending}, 32'd1);
        #3 resetn = 1'b0;
        #1;
        m_pc = RV; m_epc = '0; m_ptgt = '0; m_pend = 1'b0; m_aerr = 1'b0;
        chk_all("async_rst");
        @(posedge clk); #1 resetn = 1'b1;
        idle("post_rst", 0);
        chk("post_rst.lit", pc, 32'hBFC0_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Registered program-counter unit for the MIPS core; successor to the combinational next-PC adapter. It owns the PC register and computes the next PC for sequential, branch, jump and jump-register flow. It also adds stall handling with a held pending redirect, exception entry to a fixed vector, an EPC register, and `eret` return. It sits between decode/regfile (control-flow requests) and instruction fetch (`pc` output).

## Interface
- `ADDR_BITS`, 32: PC width; legal range 29..32.
- `RESET_VECTOR`, 32'hBFC0_0000: PC value after reset; truncated to `ADDR_BITS`.
- `EXC_VECTOR`, 32'hBFC0_0380: exception entry address; truncated to `ADDR_BITS`.
- `clk` in 1: the block's only clock; all state updates on its rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `stall` in 1: hold PC; defers jmp/jr/branch redirects.
- `pcsel` in 1: conditional branch taken.
- `jmp` in 1: unconditional jump.
- `jr` in 1: with `jmp`, selects register target.
- `imm_16` in 16: branch offset in words, signed.
- `imm_26` in 26: jump index.
- `regfile_out1` in 32: jr target; low `ADDR_BITS` used.
- `exc_req` in 1: take exception.
- `exc_pc` in ADDR_BITS: address of the faulting instruction, saved to EPC.
- `eret` in 1: return from exception.
- `pc` out ADDR_BITS: current PC (registered).
- `pc_plus4` out ADDR_BITS: `pc + 4`, combinational.
- `epc` out ADDR_BITS: saved exception PC (registered).
- `redirect_pending` out 1: a deferred redirect is held (registered).
- `addr_err` out 1: misaligned redirect detected (registered). Present only under `PC_ALIGN_CHECK_EN`; otherwise tied 0.

## Operation
- Reset values:
  - `pc` = `RESET_VECTOR`.
  - `epc` = 0.
  - `redirect_pending` = 0.
  - Pending target = 0.
  - `addr_err` = 0.
- All arithmetic is modulo 2^ADDR_BITS; `pc + 4` wraps from all-ones-minus-3 to 0.
- Target formulas:
  - Branch target = `pc + 4 + (sext(imm_16) << 2)`.
  - Jump target = `{pc_plus4[ADDR_BITS-1:28], imm_26, 2'b00}`.
  - Jr target = `regfile_out1[ADDR_BITS-1:0]`.
- Flow request priority, highest first:
  1. `exc_req`
  2. `eret`
  3. `jmp & jr`
  4. `jmp`
  5. `pcsel`
  6. pending redirect
  7. sequential
- `pcsel` together with `jmp`: `jmp` wins.
- Exception (`exc_req`=1):
  - Next `pc` = `EXC_VECTOR`; `epc` <= `exc_pc`.
  - Pending redirect cleared.
  - Takes effect even while `stall`=1.
- Eret (`eret`=1, `exc_req`=0):
  - Next `pc` = `epc`; pending redirect cleared.
  - Takes effect even while `stall`=1.
- Jmp/jr/branch while `stall`=0: next `pc` = target; pending redirect cleared.
- Jmp/jr/branch while `stall`=1:
  - `pc` holds.
  - Target is captured into the pending register; `redirect_pending` <= 1.
  - A later request during the same stall overwrites the pending target: latest wins.
- Pending redirect, `stall`=0, no new request: next `pc` = pending target; `redirect_pending` <= 0.
- Pending redirect, `stall`=0, new jmp/jr/branch in the same cycle: the new request wins; pending is discarded.
- No request, `stall`=1: `pc` holds.
- No request, `stall`=0: `pc` <= `pc_plus4`.

## Timing
- Request sampled in cycle N; new `pc` visible after the rising edge ending cycle N (1-cycle latency).
- `pc_plus4` follows `pc` combinationally, with zero latency.
- A redirect deferred during stall lands on the first edge where `stall`=0: the edge ending the first unstalled cycle.
- Asynchronous `resetn` assertion mid-stall or mid-pending immediately forces all reset values. Deassertion is expected synchronous to `clk`.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - Any selected jr or eret target with bits [1:0] ≠ 0 is not loaded.
  - Instead, `pc` <= `EXC_VECTOR` and `epc` <= the offending target.
  - `addr_err` pulses 1 for one cycle.
  - Pending-captured jr targets are checked at capture; a misaligned one redirects immediately, regardless of stall.
- `PC_ALIGN_CHECK_EN` undefined: no check; targets load as-is; `addr_err` = 0 constantly.

## Test plan
- Reset, then 3 unstalled cycles with no requests -> `pc` = BFC00000, BFC00004, BFC00008, BFC0000C.
- At `pc`=00400010, `pcsel`=1, `imm_16`=FFFE -> next `pc` = 0040000C. With `jmp`=1, `imm_26`=0000100 -> next `pc` = 00000400.
- `stall`=1, `jmp`=1, `jr`=1, `regfile_out1`=00401000 for one cycle; `stall` held 3 more cycles -> `pc` holds and `redirect_pending`=1. On release -> `pc` = 00401000 and `redirect_pending`=0.
- `stall`=1 with pending branch, then `exc_req`=1, `exc_pc`=00400020 -> `pc` = BFC00380, `epc` = 00400020, pending cleared. Next `eret` -> `pc` = 00400020.
- `pc`=FFFFFFFC, no request -> next `pc` = 00000000 (wrap).
- With `PC_ALIGN_CHECK_EN`: jr to 00401002 -> `pc` = BFC00380, `epc` = 00401002, `addr_err`=1 for one cycle. Without the macro -> `pc` = 00401002, `addr_err`=0.
